aes128_round_ctrl: RTL and testbench
====================================

# aes128_round_ctrl

Iterative round sequencer for the AES-128 encryption datapath. It steps one shared round datapath (SubBytes -> row shift -> MixColumns -> AddRoundKey) through the initial AddRoundKey, NR-1 full rounds and the final round without MixColumns. It requests each round key from the key-schedule block over a request/acknowledge handshake. It accepts blocks over a ready/start handshake and returns them over a valid/ready handshake.

## Interface
- NR, default 10: number of AES rounds; round index 0..NR, and the counter is 4 bits wide.
- PIPE_LAT, default 1: datapath latency in cycles per round, legal range 1..8.

- i_clk  in  1  single clock; all logic on the rising edge.
- i_rstn  in  1  reset, synchronous and active-low.
- i_start  in  1  block request; accepted when i_start & o_ready.
- o_ready  out  1  controller idle and able to accept i_start.
- i_abort  in  1  synchronous abort; discards the block in flight.
- o_keyReq  out  1  round-key request for round o_keyRound.
- o_keyRound  out  4  round index 0..NR; stable while o_keyReq is high and throughout EXEC.
- i_keyAck  in  1  key schedule presents round key o_keyRound this cycle.
- o_stateLoad  out  1  one-cycle strobe; state register captures the datapath output.
- o_stateSel  out  2  datapath mux selection, meaningful when o_stateLoad is high:
  - 1: plaintext ^ key
  - 2: full round
  - 3: final round, MixColumns bypassed
  - 0: never issued with a load
- o_busy  out  1  high in any state other than IDLE.
- o_valid  out  1  ciphertext in the state register is valid.
- i_outReady  in  1  consumer accepts the ciphertext when o_valid & i_outReady.

## Operation
- FSM states: IDLE, KEYREQ, EXEC, DONE. All outputs are Moore-decoded from the state and the round counter r.
- Reset (i_rstn low at an edge):
  - State becomes IDLE, r=0, EXEC wait counter=0.
  - After that edge: o_ready=1, and o_keyReq, o_stateLoad, o_busy and o_valid are 0.
  - o_keyRound=0 and o_stateSel=0.
  - Reset overrides every other input.
- IDLE:
  - o_ready=1.
  - On i_start, set r=0 and move to KEYREQ.
  - i_outReady and i_keyAck are ignored.
- KEYREQ:
  - o_keyReq=1 and o_keyRound=r.
  - Stay in KEYREQ until i_keyAck, then go to EXEC with the wait counter cleared.
  - There is no timeout.
- EXEC:
  - Lasts exactly PIPE_LAT cycles.
  - o_stateLoad=1 only on the last EXEC cycle, with o_stateSel = 1 if r=0, 2 if 1<=r<=NR-1, and 3 if r=NR.
  - After the last cycle: if r=NR, go to DONE; otherwise r=r+1 and go to KEYREQ.
  - r never wraps and never exceeds NR.
- DONE:
  - o_valid=1, held until i_outReady, then go to IDLE.
  - i_start is ignored because o_ready=0.
- i_abort:
  - In KEYREQ, EXEC or DONE: the next state is IDLE and r=0.
  - If the abort arrives on the last EXEC cycle, o_stateLoad is still issued that cycle, since it is decoded from the current state.
  - Abort wins over a simultaneous i_outReady in DONE; the block counts as dropped and a scoreboard must not expect it.
  - Abort has no effect in IDLE; i_start & i_abort in IDLE accepts the start.
- i_keyAck seen outside KEYREQ is ignored.

## Timing
- Start handshake at edge t0, with i_keyAck held high and PIPE_LAT=L:
  - KEYREQ for round 0 at t0+1.
  - Round r load strobe at t0+1+(r+1)(L+1)-1 = t0+(r+1)(L+1).
  - DONE and o_valid begin at t0+(NR+1)(L+1)+1.
  - For NR=10, L=1: loads at t0+2, t0+4, …, t0+22; o_valid at t0+23.
- Each cycle of i_keyAck delay adds one cycle to that round only.
- Minimum inter-block spacing: the cycle after the output handshake is IDLE with o_ready=1. A new start is accepted at the earliest on that cycle.
- Exactly NR+1 load strobes per completed block: one with sel=1, NR-1 with sel=2, one with sel=3.

## Test plan
- Reset then single block, NR=10, L=1, ack tied high:
  - 11 strobes at t0+2..t0+22 with step 2.
  - sel sequence 1,2×9,3.
  - o_keyRound 0..10.
  - o_valid at t0+23.
- Key stall: i_keyAck low for 3 cycles in round 5 only -> that load shifts by 3 cycles; o_valid at t0+26; o_keyRound=5 stable during the stall.
- L=3, ack high -> loads every 4 cycles starting at t0+4; o_valid at t0+45.
- Output backpressure: i_outReady low for 5 cycles in DONE, with i_start pulsed during that window -> o_valid held; no start accepted; IDLE one cycle after i_outReady.
- Abort in EXEC of round 7, and separately abort together with i_outReady in DONE -> IDLE next cycle, o_ready=1, no further strobes; the next block restarts at round 0.
- i_rstn low mid-round 4 for one cycle -> all outputs at their reset values after that edge; the following block completes normally.

Source files
------------

// File: rtl/aes128_round_ctrl.sv
// aes128_round_ctrl: iterative AES-128 round sequencer.
// Fetches each round key, then strobes one datapath load per round.
module aes128_round_ctrl #(
  parameter int NR       = 10,
  parameter int PIPE_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  output logic       o_ready,
  input  logic       i_abort,
  output logic       o_keyReq,
  output logic [3:0] o_keyRound,
  input  logic       i_keyAck,
  output logic       o_stateLoad,
  output logic [1:0] o_stateSel,
  output logic       o_busy,
  output logic       o_valid,
  input  logic       i_outReady
);

  typedef enum logic [1:0] {
    IDLE,
    KEYREQ,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] RLAST = 4'(NR);
  localparam logic [2:0] WLAST = 3'(PIPE_LAT - 1);

  state_t     state, state_n;
  logic [3:0] rnd, rnd_n;
  logic [2:0] wcnt, wcnt_n;
  logic       last;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= IDLE;
      rnd   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      rnd   <= rnd_n;
      wcnt  <= wcnt_n;
    end
  end

  assign last = (state == EXEC) && (wcnt == WLAST);

  always_comb begin
    state_n = state;
    rnd_n   = rnd;
    wcnt_n  = wcnt;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_n = KEYREQ;
          rnd_n   = '0;
        end
      end
      KEYREQ: begin
        if (i_keyAck) begin
          state_n = EXEC;
          wcnt_n  = '0;
        end
      end
      EXEC: begin
        if (!last) begin
          wcnt_n = wcnt + 3'd1;
        end else if (rnd == RLAST) begin
          state_n = DONE;
        end else begin
          state_n = KEYREQ;
          rnd_n   = rnd + 4'd1;
        end
      end
      DONE: begin
        if (i_outReady) begin
          state_n = IDLE;
          rnd_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // abort drops the block; it never blocks an IDLE start
    if (i_abort && state != IDLE) begin
      state_n = IDLE;
      rnd_n   = '0;
    end
  end

  always_comb begin
    o_ready     = 1'b0;
    o_keyReq    = 1'b0;
    o_keyRound  = '0;
    o_stateLoad = 1'b0;
    o_stateSel  = 2'd0;
    o_busy      = 1'b1;
    o_valid     = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
      end
      KEYREQ: begin
        o_keyReq   = 1'b1;
        o_keyRound = rnd;
      end
      EXEC: begin
        o_keyRound  = rnd;
        o_stateLoad = last;
        if (last) begin
          if (rnd == 4'd0)
            o_stateSel = 2'd1;
          else if (rnd == RLAST)
            o_stateSel = 2'd3;
          else
            o_stateSel = 2'd2;
        end
      end
      DONE: begin
        o_valid = 1'b1;
      end
      default: o_busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// tb_aes128_round_ctrl: randomized self-checking bench for the round sequencer.
// A round-timing model predicts every load strobe, selection and valid cycle.
module tb_aes128_round_ctrl;

  localparam int NR = 10;

  logic       clk = 1'b0;
  logic       rstn      [2];
  logic       start     [2];
  logic       abort     [2];
  logic       ack       [2];
  logic       out_rdy   [2];
  logic       ready     [2];
  logic       key_req   [2];
  logic [3:0] key_round [2];
  logic       load      [2];
  logic [1:0] sel       [2];
  logic       busy      [2];
  logic       valid     [2];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  int lq[$];
  int krq[$];
  int t0, v_cyc, v_cnt, end_cyc;
  logic [10:0] end_obs;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_round_ctrl #(.NR(NR), .PIPE_LAT(1)) u0 (
    .i_clk(clk), .i_rstn(rstn[0]), .i_start(start[0]),
    .o_ready(ready[0]), .i_abort(abort[0]), .o_keyReq(key_req[0]),
    .o_keyRound(key_round[0]), .i_keyAck(ack[0]),
    .o_stateLoad(load[0]), .o_stateSel(sel[0]), .o_busy(busy[0]),
    .o_valid(valid[0]), .i_outReady(out_rdy[0])
  );

  aes128_round_ctrl #(.NR(NR), .PIPE_LAT(3)) u1 (
    .i_clk(clk), .i_rstn(rstn[1]), .i_start(start[1]),
    .o_ready(ready[1]), .i_abort(abort[1]), .o_keyReq(key_req[1]),
    .o_keyRound(key_round[1]), .i_keyAck(ack[1]),
    .o_stateLoad(load[1]), .o_stateSel(sel[1]), .o_busy(busy[1]),
    .o_valid(valid[1]), .i_outReady(out_rdy[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [10:0] obs(input int k);
    return {ready[k], key_req[k], load[k], busy[k], valid[k],
            key_round[k], sel[k]};
  endfunction

  // each round: one request cycle, any ack stall, then L execute cycles
  function automatic int exp_load(input int t, input int l, input int r,
                                  input int sr, input int sn);
    int c;
    c = t;
    for (int i = 0; i <= r; i++)
      c += 1 + l + ((i == sr) ? sn : 0);
    return c;
  endfunction

  function automatic int exp_code(input int t, input int l, input int r,
                                  input int sr, input int sn);
    int s;
    s = (r == 0) ? 1 : ((r == NR) ? 3 : 2);
    return exp_load(t, l, r, sr, sn) * 64 + s * 16 + r;
  endfunction

  task automatic drive_block(input int k, input int sr, input int sn,
                             input int od, input bit poke, input int kr,
                             input bit kill_rst, input bit ad);
    int scnt, dcnt;
    bit fin, fin_n;
    scnt = 0; dcnt = 0; fin = 0; fin_n = 0;
    lq.delete(); krq.delete();
    v_cyc = -1; v_cnt = 0; end_cyc = -1; end_obs = 'x;
    start[k] = 1'b1;
    t0 = cyc;
    for (int n = 0; n < 600 && !fin; n++) begin
      @(negedge clk);
      if (load[k])
        lq.push_back(cyc * 64 + int'(sel[k]) * 16 + int'(key_round[k]));
      if (valid[k] && v_cyc < 0) v_cyc = cyc;
      if (fin_n) begin
        end_cyc = cyc;
        end_obs = obs(k);
        fin = 1;
      end else begin
        start[k] = 1'b0; ack[k] = 1'b1;
        abort[k] = 1'b0; out_rdy[k] = 1'b0;
        if (key_req[k] && int'(key_round[k]) == sr && scnt < sn) begin
          ack[k] = 1'b0;
          scnt++;
          krq.push_back(int'(key_round[k]));
        end
        if (kr >= 0 && busy[k] && !key_req[k] && !valid[k] &&
            int'(key_round[k]) == kr) begin
          if (kill_rst) rstn[k] = 1'b0;
          else abort[k] = 1'b1;
          fin_n = 1;
        end
        if (valid[k]) begin
          v_cnt++;
          if (dcnt < od) begin
            dcnt++;
            start[k] = poke;
          end else begin
            out_rdy[k] = 1'b1;
            abort[k] = ad;
            fin_n = 1;
          end
        end
      end
    end
    start[k] = 1'b0; abort[k] = 1'b0; out_rdy[k] = 1'b0;
    ack[k] = 1'b1; rstn[k] = 1'b1;
  endtask

  task automatic idle_watch(input int k, input int n, output int act);
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_req[k] || load[k] || busy[k] || !ready[k]) act++;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 0; start[k] = 1; abort[k] = 1;
      ack[k] = 1; out_rdy[k] = 1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (obs(k) !== 11'h400) begin
        miscompares++;
        $display("FAIL reset u%0d: got %h want %h", k, obs(k), 11'h400);
      end
      rstn[k] = 1; start[k] = 0; abort[k] = 0; out_rdy[k] = 0;
    end
  endtask

  task automatic test_single();
    drive_block(0, -1, 0, 0, 0, -1, 0, 0);
    vectors++;
    if (lq.size() != NR + 1) begin
      miscompares++;
      $display("FAIL single count: got %0d want %0d", lq.size(), NR + 1);
    end
    foreach (lq[i]) begin
      vectors++;
      if (lq[i] !== exp_code(t0, 1, i, -1, 0)) begin
        miscompares++;
        $display("FAIL single load %0d: got t=%0d sel=%0d r=%0d want code %0d",
                 i, lq[i] / 64 - t0, (lq[i] / 16) % 4, lq[i] % 16,
                 exp_code(t0, 1, i, -1, 0) - t0 * 64);
      end
    end
    vectors++;
    if (v_cyc - t0 != 23 || end_cyc != v_cyc + 1 ||
        end_obs[10:6] !== 5'b10000) begin
      miscompares++;
      $display("FAIL single done: got valid t0+%0d end %0d obs %b want t0+23",
               v_cyc - t0, end_cyc - v_cyc, end_obs[10:6]);
    end
  endtask

  task automatic test_key_stall();
    drive_block(0, 5, 3, 0, 0, -1, 0, 0);
    foreach (lq[i]) begin
      vectors++;
      if (lq[i] !== exp_code(t0, 1, i, 5, 3)) begin
        miscompares++;
        $display("FAIL stall load %0d: got t=%0d sel=%0d r=%0d want t=%0d",
                 i, lq[i] / 64 - t0, (lq[i] / 16) % 4, lq[i] % 16,
                 exp_load(t0, 1, i, 5, 3) - t0);
      end
    end
    vectors++;
    if (lq.size() != NR + 1 || v_cyc - t0 != 26) begin
      miscompares++;
      $display("FAIL stall valid: got %0d loads valid t0+%0d want 11, t0+26",
               lq.size(), v_cyc - t0);
    end
    vectors++;
    if (krq.size() != 3 || krq.sum() != 15) begin
      miscompares++;
      $display("FAIL stall keyround: got %0d cycles sum %0d want 3, 15",
               krq.size(), krq.sum());
    end
  endtask

  task automatic test_lat3();
    drive_block(1, -1, 0, 0, 0, -1, 0, 0);
    foreach (lq[i]) begin
      vectors++;
      if (lq[i] !== exp_code(t0, 3, i, -1, 0)) begin
        miscompares++;
        $display("FAIL lat3 load %0d: got t=%0d sel=%0d r=%0d want t=%0d",
                 i, lq[i] / 64 - t0, (lq[i] / 16) % 4, lq[i] % 16,
                 exp_load(t0, 3, i, -1, 0) - t0);
      end
    end
    vectors++;
    if (lq.size() != NR + 1 || v_cyc - t0 != 45) begin
      miscompares++;
      $display("FAIL lat3 valid: got %0d loads valid t0+%0d want 11, t0+45",
               lq.size(), v_cyc - t0);
    end
  endtask

  task automatic test_backpressure();
    int act;
    drive_block(0, -1, 0, 5, 1, -1, 0, 0);
    vectors++;
    if (v_cnt != 6 || end_cyc != v_cyc + 6 || end_obs[10:6] !== 5'b10000) begin
      miscompares++;
      $display("FAIL backpressure: got valid %0d cycles end +%0d obs %b want 6, +6",
               v_cnt, end_cyc - v_cyc, end_obs[10:6]);
    end
    idle_watch(0, 4, act);
    vectors++;
    if (act != 0) begin
      miscompares++;
      $display("FAIL backpressure idle: got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_abort_exec();
    int act;
    for (int k = 0; k < 2; k++) begin
      drive_block(k, -1, 0, 0, 0, 7, 0, 0);
      vectors++;
      if (lq.size() != ((k == 0) ? 8 : 7) || v_cyc != -1 ||
          end_obs[10:6] !== 5'b10000) begin
        miscompares++;
        $display("FAIL abort exec u%0d: got %0d loads obs %b want %0d",
                 k, lq.size(), end_obs[10:6], (k == 0) ? 8 : 7);
      end
      idle_watch(k, 3, act);
      vectors++;
      if (act != 0) begin
        miscompares++;
        $display("FAIL abort exec idle u%0d: got %0d active want 0", k, act);
      end
    end
  endtask

  task automatic test_abort_done();
    drive_block(0, -1, 0, 0, 0, -1, 0, 1);
    vectors++;
    if (v_cnt != 1 || end_cyc != v_cyc + 1 || end_obs[10:6] !== 5'b10000) begin
      miscompares++;
      $display("FAIL abort done: got valid %0d end +%0d obs %b want 1, +1",
               v_cnt, end_cyc - v_cyc, end_obs[10:6]);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 2; b++) begin
      drive_block(0, -1, 0, 0, 0, -1, 0, 0);
      vectors++;
      if (lq.size() != NR + 1 || lq[0] !== exp_code(t0, 1, 0, -1, 0) ||
          lq[NR] !== exp_code(t0, 1, NR, -1, 0)) begin
        miscompares++;
        $display("FAIL back_to_back %0d: got %0d loads first %0d want 11, %0d",
                 b, lq.size(), lq[0] - t0 * 64, exp_code(t0, 1, 0, -1, 0) - t0 * 64);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_block(0, -1, 0, 0, 0, 4, 1, 0);
    vectors++;
    if (end_obs !== 11'h400 || lq.size() != 5) begin
      miscompares++;
      $display("FAIL reset mid: got obs %h loads %0d want 400, 5",
               end_obs, lq.size());
    end
    drive_block(0, -1, 0, 0, 0, -1, 0, 0);
    foreach (lq[i]) begin
      vectors++;
      if (lq[i] !== exp_code(t0, 1, i, -1, 0)) begin
        miscompares++;
        $display("FAIL reset mid load %0d: got t=%0d sel=%0d r=%0d",
                 i, lq[i] / 64 - t0, (lq[i] / 16) % 4, lq[i] % 16);
      end
    end
    vectors++;
    if (lq.size() != NR + 1 || v_cyc - t0 != 23) begin
      miscompares++;
      $display("FAIL reset mid block: got %0d loads valid t0+%0d want 11, t0+23",
               lq.size(), v_cyc - t0);
    end
  endtask

  task automatic test_random();
    int k, sr, sn, od;
    for (int it = 0; it < 8; it++) begin
      k  = int'($urandom_range(0, 1));
      sr = int'($urandom_range(0, NR));
      sn = int'($urandom_range(0, 4));
      od = int'($urandom_range(0, 3));
      drive_block(k, sr, sn, od, 1, -1, 0, 0);
      foreach (lq[i]) begin
        vectors++;
        if (lq[i] !== exp_code(t0, lat(k), i, sr, sn)) begin
          miscompares++;
          $display("FAIL random %0d load %0d: got t=%0d sel=%0d r=%0d want t=%0d",
                   it, i, lq[i] / 64 - t0, (lq[i] / 16) % 4, lq[i] % 16,
                   exp_load(t0, lat(k), i, sr, sn) - t0);
        end
      end
      vectors++;
      if (lq.size() != NR + 1 ||
          v_cyc != exp_load(t0, lat(k), NR, sr, sn) + 1 ||
          end_cyc != v_cyc + od + 1) begin
        miscompares++;
        $display("FAIL random %0d end: got %0d loads valid t0+%0d end +%0d want t0+%0d",
                 it, lq.size(), v_cyc - t0, end_cyc - v_cyc,
                 exp_load(t0, lat(k), NR, sr, sn) + 1 - t0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_key_stall();
    test_lat3();
    test_backpressure();
    test_abort_exec();
    test_abort_done();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
